// File: rtl/mem_alloc_engine_pkg.sv
// Shared types and constants for the memory allocation engine.
package mem_alloc_engine_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_ACK,
        ST_WAIT
    } alloc_state_t;

    localparam int unsigned FLASH_TAG_BIT = 31;

    // Occupancy width: must hold 0..2^depth_log2 inclusive.
    function automatic int unsigned count_width(input int unsigned depth_log2);
        return $clog2((1 << depth_log2) + 1);
    endfunction

endpackage

// File: rtl/mem_alloc_freelist.sv
// Circular RAM FIFO of free DRAM addresses, with a bulk-init write port.
module mem_alloc_freelist
    import mem_alloc_engine_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned NUM_CHUNKS = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             init_we,
    input  logic [DEPTH_LOG2-1:0]            init_addr,
    input  logic [31:0]                      init_data,
    input  logic                             init_last,
    input  logic                             push,
    input  logic [31:0]                      push_data,
    input  logic                             pop,
    output logic [31:0]                      rd_data,
    output logic [count_width(DEPTH_LOG2)-1:0] count,
    output logic                             full,
    output logic                             empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = count_width(DEPTH_LOG2);
    localparam logic [CW-1:0]         INIT_COUNT  = CW'(NUM_CHUNKS);
    localparam logic [CW-1:0]         FULL_COUNT  = CW'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] INIT_WR_PTR = DEPTH_LOG2'(NUM_CHUNKS);

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;

    // Storage is never reset; INIT rewrites every managed slot.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_addr] <= init_data;
        end else if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (init_last) begin
            wr_ptr <= INIT_WR_PTR;
            rd_ptr <= '0;
            count  <= INIT_COUNT;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_alloc_engine.sv
// On-chip allocator serving DRAM addresses from a free list and flash
// addresses from a wrapping bump pointer, with memcached flush handshake.
module mem_alloc_engine
    import mem_alloc_engine_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2        = 10,
    parameter int unsigned NUM_CHUNKS        = 1024,
    parameter logic [31:0] DRAM_BASE         = 32'h0000_0000,
    parameter logic [31:0] CHUNK_BYTES       = 32'd2048,
    parameter logic [31:0] FLASH_BASE        = 32'h0000_0000,
    parameter logic [31:0] FLASH_CHUNK_BYTES = 32'd4096,
    parameter int unsigned FLASH_CHUNKS      = 4096
) (
    input  logic                               ACLK,
    input  logic                               Axi_resetn,
    input  logic [31:0]                        memcached2memAllocation_data,
    input  logic                               memcached2memAllocation_valid,
    output logic                               memcached2memAllocation_ready,
    output logic [31:0]                        memAllocation2memcached_dram_data,
    output logic                               memAllocation2memcached_dram_valid,
    input  logic                               memAllocation2memcached_dram_ready,
    output logic [31:0]                        memAllocation2memcached_flash_data,
    output logic                               memAllocation2memcached_flash_valid,
    input  logic                               memAllocation2memcached_flash_ready,
    input  logic                               flushReq,
    output logic                               flushAck,
    input  logic                               flushDone,
    output logic [count_width(DEPTH_LOG2)-1:0] free_count,
    output logic [15:0]                        drop_count
);

    localparam logic [DEPTH_LOG2-1:0] LAST_IDX       = DEPTH_LOG2'(NUM_CHUNKS - 1);
    localparam logic [31:0]           FLASH_LAST_IDX = 32'(FLASH_CHUNKS - 1);

    alloc_state_t          state;
    alloc_state_t          state_next;
    logic [DEPTH_LOG2-1:0] init_idx;
    logic                  init_last;
    logic                  run_go;
    logic                  ready_int;
    logic                  fl_push;
    logic                  fl_pop;
    logic                  flash_pop;
    logic                  drop_evt;
    logic                  fl_full;
    logic                  fl_empty;
    logic [31:0]           fl_rd_data;
    logic [31:0]           init_data;
    logic [31:0]           flash_ptr;
    logic [31:0]           flash_idx;
    logic                  reclaim_xfer;

    assign init_last = (state == ST_INIT) && (init_idx == LAST_IDX);
    assign init_data = DRAM_BASE + 32'(init_idx) * CHUNK_BYTES;

    // A flush request in RUN withdraws every valid/ready so no handshake
    // can complete in the cycle the engine commits to flushing.
    always_comb begin
        state_next                          = state;
        run_go                              = 1'b0;
        ready_int                           = 1'b0;
        flushAck                            = 1'b0;
        memAllocation2memcached_dram_valid  = 1'b0;
        memAllocation2memcached_flash_valid = 1'b0;
        case (state)
            ST_INIT: begin
                ready_int = 1'b1;
                if (init_idx == LAST_IDX) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (flushReq) begin
                    state_next = ST_ACK;
                end else begin
                    run_go                              = 1'b1;
                    ready_int                           = !fl_full;
                    memAllocation2memcached_dram_valid  = !fl_empty;
                    memAllocation2memcached_flash_valid = 1'b1;
                end
            end
            ST_ACK: begin
                ready_int  = 1'b1;
                flushAck   = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                ready_int = 1'b1;
                if (flushDone) state_next = ST_INIT;
            end
            default: state_next = ST_INIT;
        endcase
    end

    assign memcached2memAllocation_ready      = ready_int & Axi_resetn;
    assign reclaim_xfer = run_go && memcached2memAllocation_valid && ready_int;
    assign fl_push      = reclaim_xfer && !memcached2memAllocation_data[FLASH_TAG_BIT];
    assign drop_evt     = reclaim_xfer &&  memcached2memAllocation_data[FLASH_TAG_BIT];
    assign fl_pop       = memAllocation2memcached_dram_valid && memAllocation2memcached_dram_ready;
    assign flash_pop    = memAllocation2memcached_flash_valid && memAllocation2memcached_flash_ready;

    assign memAllocation2memcached_dram_data  = fl_rd_data;
    assign memAllocation2memcached_flash_data = flash_ptr;

    always_ff @(posedge ACLK or negedge Axi_resetn) begin
        if (!Axi_resetn) begin
            state      <= ST_INIT;
            init_idx   <= '0;
            flash_ptr  <= FLASH_BASE;
            flash_idx  <= '0;
            drop_count <= '0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) begin
                init_idx <= init_last ? '0 : init_idx + 1'b1;
            end
            if (init_last) begin
                flash_ptr <= FLASH_BASE;
                flash_idx <= '0;
            end else if (flash_pop) begin
                if (flash_idx == FLASH_LAST_IDX) begin
                    flash_ptr <= FLASH_BASE;
                    flash_idx <= '0;
                end else begin
                    flash_ptr <= flash_ptr + FLASH_CHUNK_BYTES;
                    flash_idx <= flash_idx + 1'b1;
                end
            end
            if (drop_evt && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

    mem_alloc_freelist #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .NUM_CHUNKS (NUM_CHUNKS)
    ) u_freelist (
        .clk       (ACLK),
        .rst_n     (Axi_resetn),
        .init_we   (state == ST_INIT),
        .init_addr (init_idx),
        .init_data (init_data),
        .init_last (init_last),
        .push      (fl_push),
        .push_data (memcached2memAllocation_data),
        .pop       (fl_pop),
        .rd_data   (fl_rd_data),
        .count     (free_count),
        .full      (fl_full),
        .empty     (fl_empty)
    );

endmodule

// File: tb/tb_mem_alloc_engine.sv
// Self-checking bench for mem_alloc_engine against a queue-based allocator model.
module tb_mem_alloc_engine;

    localparam int unsigned DL2  = 3;
    localparam int unsigned CAP  = 8;
    localparam int unsigned NCH  = 4;
    localparam logic [31:0] DBASE = 32'h0000_1000;
    localparam logic [31:0] CB    = 32'd2048;
    localparam logic [31:0] FBASE = 32'h0000_0000;
    localparam logic [31:0] FCB   = 32'h0000_1000;
    localparam int unsigned FCH  = 2;

    logic        ACLK = 1'b0;
    logic        Axi_resetn = 1'b0;
    logic [31:0] rc_data = '0;
    logic        rc_valid = 1'b0;
    logic        rc_ready;
    logic [31:0] dram_data;
    logic        dram_valid;
    logic        dram_ready = 1'b0;
    logic [31:0] flash_data;
    logic        flash_valid;
    logic        flash_ready = 1'b0;
    logic        flushReq = 1'b0;
    logic        flushAck;
    logic        flushDone = 1'b0;
    logic [3:0]  free_count;
    logic [15:0] drop_count;

    always #5 ACLK = ~ACLK;

    mem_alloc_engine #(
        .DEPTH_LOG2        (DL2),
        .NUM_CHUNKS        (NCH),
        .DRAM_BASE         (DBASE),
        .CHUNK_BYTES       (CB),
        .FLASH_BASE        (FBASE),
        .FLASH_CHUNK_BYTES (FCB),
        .FLASH_CHUNKS      (FCH)
    ) dut (
        .ACLK                               (ACLK),
        .Axi_resetn                         (Axi_resetn),
        .memcached2memAllocation_data       (rc_data),
        .memcached2memAllocation_valid      (rc_valid),
        .memcached2memAllocation_ready      (rc_ready),
        .memAllocation2memcached_dram_data  (dram_data),
        .memAllocation2memcached_dram_valid (dram_valid),
        .memAllocation2memcached_dram_ready (dram_ready),
        .memAllocation2memcached_flash_data (flash_data),
        .memAllocation2memcached_flash_valid(flash_valid),
        .memAllocation2memcached_flash_ready(flash_ready),
        .flushReq                           (flushReq),
        .flushAck                           (flushAck),
        .flushDone                          (flushDone),
        .free_count                         (free_count),
        .drop_count                         (drop_count)
    );

    int          checks = 0;
    int          passed = 0;
    logic [31:0] fl[$];
    int unsigned fidx = 0;
    int unsigned drops_m = 0;

    function automatic void model_init();
        fl.delete();
        for (int i = 0; i < int'(NCH); i++) fl.push_back(DBASE + 32'(i) * CB);
        fidx = 0;
    endfunction

    function automatic logic [31:0] model_flash();
        return FBASE + 32'(fidx) * FCB;
    endfunction

    function automatic void model_flash_pop();
        fidx = (fidx + 1) % FCH;
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle();
        rc_valid = 1'b0; rc_data = '0; dram_ready = 1'b0; flash_ready = 1'b0;
        flushReq = 1'b0; flushDone = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        Axi_resetn = 1'b0;
        #12;
        checks++; if (dram_valid !== 1'b0) $display("FAIL rst_dram_valid got %0b want 0", dram_valid); else passed++;
        checks++; if (flash_valid !== 1'b0) $display("FAIL rst_flash_valid got %0b want 0", flash_valid); else passed++;
        checks++; if (rc_ready !== 1'b0) $display("FAIL rst_ready got %0b want 0", rc_ready); else passed++;
        checks++; if (flushAck !== 1'b0) $display("FAIL rst_ack got %0b want 0", flushAck); else passed++;
        checks++; if (free_count !== 4'd0) $display("FAIL rst_free got %0d want 0", free_count); else passed++;
        checks++; if (drop_count !== 16'd0) $display("FAIL rst_drop got %0d want 0", drop_count); else passed++;
        checks++; if (flash_data !== FBASE) $display("FAIL rst_flash_data got %h want %h", flash_data, FBASE); else passed++;
    endtask

    // Runs NCH cycles of INIT and checks dram_valid rises exactly after the last write.
    task automatic run_init(input string tag);
        for (int k = 1; k <= int'(NCH); k++) begin
            checks++; if (rc_ready !== 1'b1) $display("FAIL %s_init_ready got %0b want 1", tag, rc_ready); else passed++;
            tick();
            checks++;
            if (dram_valid !== (k == int'(NCH)))
                $display("FAIL %s_init_valid cycle %0d got %0b want %0b", tag, k, dram_valid, k == int'(NCH));
            else passed++;
        end
        model_init();
        checks++; if (free_count !== 4'(NCH)) $display("FAIL %s_init_free got %0d want %0d", tag, free_count, NCH); else passed++;
        checks++; if (dram_data !== DBASE) $display("FAIL %s_init_first got %h want %h", tag, dram_data, DBASE); else passed++;
        checks++; if (flash_data !== FBASE) $display("FAIL %s_init_flash got %h want %h", tag, flash_data, FBASE); else passed++;
    endtask

    task automatic test_init();
        @(posedge ACLK); #1;
        Axi_resetn = 1'b1;
        #1;
        run_init("boot");
    endtask

    task automatic test_drain();
        dram_ready = 1'b1;
        for (int i = 0; i < int'(NCH); i++) begin
            #1;
            checks++; if (dram_data !== fl[0]) $display("FAIL drain_data[%0d] got %h want %h", i, dram_data, fl[0]); else passed++;
            void'(fl.pop_front());
            tick();
        end
        dram_ready = 1'b0;
        #1;
        checks++; if (dram_valid !== 1'b0) $display("FAIL drain_valid got %0b want 0", dram_valid); else passed++;
        checks++; if (free_count !== 4'd0) $display("FAIL drain_free got %0d want 0", free_count); else passed++;
    endtask

    task automatic test_reclaim_empty();
        rc_valid = 1'b1; rc_data = 32'h0000_1800;
        #1;
        checks++; if (rc_ready !== 1'b1) $display("FAIL recl_ready got %0b want 1", rc_ready); else passed++;
        tick();
        fl.push_back(32'h0000_1800);
        rc_valid = 1'b0;
        #1;
        checks++; if (dram_valid !== 1'b1) $display("FAIL recl_valid got %0b want 1", dram_valid); else passed++;
        checks++; if (dram_data !== 32'h0000_1800) $display("FAIL recl_data got %h want 00001800", dram_data); else passed++;
        checks++; if (free_count !== 4'd1) $display("FAIL recl_free got %0d want 1", free_count); else passed++;
    endtask

    task automatic test_push_pop();
        rc_valid = 1'b1; rc_data = 32'h0000_2800;
        tick();
        fl.push_back(32'h0000_2800);
        rc_data = 32'h0000_2000; dram_ready = 1'b1;
        #1;
        checks++; if (dram_data !== 32'h0000_1800) $display("FAIL pp_head got %h want 00001800", dram_data); else passed++;
        tick();
        void'(fl.pop_front());
        fl.push_back(32'h0000_2000);
        rc_valid = 1'b0; dram_ready = 1'b0;
        #1;
        checks++; if (free_count !== 4'd2) $display("FAIL pp_free got %0d want 2", free_count); else passed++;
        dram_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (dram_data !== fl[0]) $display("FAIL pp_order[%0d] got %h want %h", i, dram_data, fl[0]); else passed++;
            void'(fl.pop_front());
            tick();
        end
        dram_ready = 1'b0;
    endtask

    task automatic test_flash();
        flash_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (flash_valid !== 1'b1) $display("FAIL flash_valid[%0d] got %0b want 1", i, flash_valid); else passed++;
            checks++; if (flash_data !== model_flash()) $display("FAIL flash_data[%0d] got %h want %h", i, flash_data, model_flash()); else passed++;
            model_flash_pop();
            tick();
        end
        flash_ready = 1'b0;
    endtask

    task automatic test_drop();
        rc_valid = 1'b1; rc_data = 32'h8000_0000;
        #1;
        checks++; if (rc_ready !== 1'b1) $display("FAIL drop_ready got %0b want 1", rc_ready); else passed++;
        tick();
        drops_m++;
        rc_valid = 1'b0;
        #1;
        checks++; if (drop_count !== 16'(drops_m)) $display("FAIL drop_count got %0d want %0d", drop_count, drops_m); else passed++;
        checks++; if (free_count !== 4'(fl.size())) $display("FAIL drop_free got %0d want %0d", free_count, fl.size()); else passed++;
    endtask

    task automatic test_full();
        rc_valid = 1'b1;
        while (fl.size() < CAP) begin
            rc_data = {1'b0, 16'h0, 15'(fl.size() * 64)};
            tick();
            fl.push_back(rc_data);
        end
        rc_data = 32'h0000_7000;
        #1;
        checks++; if (rc_ready !== 1'b0) $display("FAIL full_ready got %0b want 0", rc_ready); else passed++;
        tick();
        rc_valid = 1'b0;
        #1;
        checks++; if (free_count !== 4'(CAP)) $display("FAIL full_free got %0d want %0d", free_count, CAP); else passed++;
    endtask

    task automatic test_random(input int n);
        logic [31:0] d;
        logic        v, dr, fr, exp_dv, exp_rdy;
        for (int c = 0; c < n; c++) begin
            d = $urandom;
            if ($urandom_range(0, 3) != 0) d[31] = 1'b0;
            v  = (c < n / 2) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            dr = (c < n / 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            fr = 1'(($urandom_range(0, 1)));
            rc_data = d; rc_valid = v; dram_ready = dr; flash_ready = fr;
            #1;
            exp_dv  = (fl.size() != 0);
            exp_rdy = (fl.size() != CAP);
            checks++; if (dram_valid !== exp_dv) $display("FAIL rnd_dvalid c%0d got %0b want %0b", c, dram_valid, exp_dv); else passed++;
            if (exp_dv) begin
                checks++; if (dram_data !== fl[0]) $display("FAIL rnd_ddata c%0d got %h want %h", c, dram_data, fl[0]); else passed++;
            end
            checks++; if (rc_ready !== exp_rdy) $display("FAIL rnd_ready c%0d got %0b want %0b", c, rc_ready, exp_rdy); else passed++;
            checks++; if (free_count !== 4'(fl.size())) $display("FAIL rnd_free c%0d got %0d want %0d", c, free_count, fl.size()); else passed++;
            checks++; if (flash_data !== model_flash()) $display("FAIL rnd_flash c%0d got %h want %h", c, flash_data, model_flash()); else passed++;
            checks++; if (drop_count !== 16'(drops_m)) $display("FAIL rnd_drop c%0d got %0d want %0d", c, drop_count, drops_m); else passed++;
            if (dr && exp_dv) void'(fl.pop_front());
            if (v && exp_rdy) begin
                if (d[31]) begin
                    if (drops_m < 16'hFFFF) drops_m++;
                end else fl.push_back(d);
            end
            if (fr) model_flash_pop();
            tick();
        end
        idle();
    endtask

    task automatic test_flush();
        flushReq = 1'b1; dram_ready = 1'b1; flash_ready = 1'b1;
        tick();
        checks++; if (flushAck !== 1'b1) $display("FAIL flush_ack got %0b want 1", flushAck); else passed++;
        checks++; if (dram_valid !== 1'b0) $display("FAIL flush_dvalid got %0b want 0", dram_valid); else passed++;
        checks++; if (flash_valid !== 1'b0) $display("FAIL flush_fvalid got %0b want 0", flash_valid); else passed++;
        flushReq = 1'b0;
        rc_valid = 1'b1; rc_data = 32'h8000_4000;
        tick();
        checks++; if (flushAck !== 1'b0) $display("FAIL flush_ack_pulse got %0b want 0", flushAck); else passed++;
        checks++; if (rc_ready !== 1'b1) $display("FAIL wait_ready got %0b want 1", rc_ready); else passed++;
        tick();
        rc_valid = 1'b0;
        #1;
        checks++; if (drop_count !== 16'(drops_m)) $display("FAIL wait_drop got %0d want %0d", drop_count, drops_m); else passed++;
        flushDone = 1'b1;
        tick();
        flushDone = 1'b0; dram_ready = 1'b0; flash_ready = 1'b0;
        #1;
        run_init("flush");
    endtask

    task automatic test_reflush();
        flushReq = 1'b1;
        tick();
        checks++; if (flushAck !== 1'b1) $display("FAIL reflush_ack1 got %0b want 1", flushAck); else passed++;
        tick();
        flushDone = 1'b1;
        tick();
        flushDone = 1'b0;
        for (int k = 0; k < int'(NCH); k++) tick();
        checks++; if (flushAck !== 1'b0) $display("FAIL reflush_run got %0b want 0", flushAck); else passed++;
        checks++; if (free_count !== 4'(NCH)) $display("FAIL reflush_free got %0d want %0d", free_count, NCH); else passed++;
        tick();
        checks++; if (flushAck !== 1'b1) $display("FAIL reflush_ack2 got %0b want 1", flushAck); else passed++;
        flushReq = 1'b0;
        tick();
        flushDone = 1'b1;
        tick();
        flushDone = 1'b0;
        #1;
        run_init("reflush");
    endtask

    task automatic test_mid_reset();
        flushReq = 1'b1;
        tick(); tick();
        flushReq = 1'b0; flushDone = 1'b1;
        tick();
        flushDone = 1'b0;
        tick();
        Axi_resetn = 1'b0;
        #2;
        drops_m = 0;
        checks++; if (free_count !== 4'd0) $display("FAIL mrst_free got %0d want 0", free_count); else passed++;
        checks++; if (drop_count !== 16'd0) $display("FAIL mrst_drop got %0d want 0", drop_count); else passed++;
        checks++; if (rc_ready !== 1'b0) $display("FAIL mrst_ready got %0b want 0", rc_ready); else passed++;
        @(posedge ACLK); #1;
        Axi_resetn = 1'b1;
        #1;
        run_init("mrst");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_init();
        test_drain();
        test_reclaim_empty();
        test_push_pop();
        test_flash();
        test_drop();
        test_full();
        test_random(400);
        test_flush();
        test_reflush();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
